sample_uart_tx: RTL and testbench

- Downstream consumer of the processor's output strobe (txtE) and output data word (SrcBE).
- Captures each 32-bit sample the processor emits into a small synchronous FIFO.
- Serializes each captured word as 4 UART 8N1 bytes on a single tx line toward the host PC.
- Decouples the processor's pipeline rate from the much slower serial link; flags words dropped on overflow.

---
 rtl/uart_pkg.sv | 9 +
 rtl/sample_fifo.sv | 53 +++++
 rtl/sample_uart_tx.sv | 125 ++++++++++++
 tb/tb_sample_uart_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the sample UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam int BITS_PER_BYTE  = 8;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous word FIFO; pushes into a full FIFO and pops from an empty one are ignored.
module sample_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [W-1:0]            din,
   output logic [W-1:0]            dout,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic          doPush;
   logic          doPop;

   assign full   = (count == (PW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign dout   = mem[rdPtr];

   // NOTE: the storage array is deliberately not reset; pointers and count alone say which entries are valid, so it stays a plain RAM.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= din;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sample_uart_tx.sv
// Buffers 32-bit processor samples and sends each as four 8N1 bytes, MSB byte first.
module sample_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8,
   parameter int DATA_W       = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         tx,
   output logic                         busy,
   output logic                         full,
   output logic                         overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LastBit  = 3'(BITS_PER_BYTE - 1);
   localparam logic [1:0]    LastByte = 2'(BYTES_PER_WORD - 1);

   tx_state_t                  state;
   tx_state_t                  nextState;
   logic [CW-1:0]              baudCnt;
   logic [2:0]                 bitIdx;
   logic [1:0]                 byteIdx;
   logic [DATA_W-1:0]          shiftReg;
   logic [BITS_PER_BYTE-1:0]   curByte;
   logic [DATA_W-1:0]          fifoDout;
   logic                       fifoEmpty;
   logic                       pop;
   logic                       baudDone;
   logic                       txNext;

   sample_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) uFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (pop),
      .din   (wr_data),
      .dout  (fifoDout),
      .count (fifo_count),
      .full  (full),
      .empty (fifoEmpty)
   );

   assign busy     = (state != IDLE);
   assign baudDone = (baudCnt == BaudLast);
   assign curByte  = shiftReg[DATA_W-1 -: BITS_PER_BYTE];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
      nextState = state;
      pop       = 1'b0;
      txNext    = 1'b1;
      case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               pop       = 1'b1;
               nextState = START;
            end
         end
         START: begin
            txNext = 1'b0;
            if (baudDone) nextState = DATA;
         end
         DATA: begin
            txNext = curByte[bitIdx];
            if (baudDone && bitIdx == LastBit) nextState = STOP;
         end
         STOP: begin
            if (baudDone) nextState = (byteIdx == LastByte) ? IDLE : START;
         end
         default: nextState = IDLE;
      endcase
   end

   // Current byte always sits in the top of shiftReg; it moves up by one byte after each stop bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baudCnt  <= '0;
         bitIdx   <= '0;
         byteIdx  <= '0;
         shiftReg <= '0;
      end else if (state == IDLE) begin
         baudCnt <= '0;
         if (pop) begin
            shiftReg <= fifoDout;
            byteIdx  <= '0;
         end
      end else if (baudDone) begin
         baudCnt <= '0;
         if (state == START) begin
            bitIdx <= '0;
         end else if (state == DATA) begin
            bitIdx <= bitIdx + 1'b1;
         end else if (state == STOP && byteIdx != LastByte) begin
            byteIdx  <= byteIdx + 1'b1;
            shiftReg <= shiftReg << BITS_PER_BYTE;
         end
      end else begin
         baudCnt <= baudCnt + 1'b1;
      end
   end

   // Line is registered so it never glitches; async reset forces it idle at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx       <= 1'b1;
         overflow <= 1'b0;
      end else begin
         tx <= txNext;
         if (wr_en && full) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Scoreboard bench: writes queue expected bytes, a line monitor decodes tx and compares.
module tb_sample_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        tx;
   logic        busy;
   logic        full;
   logic        overflow;
   logic [2:0]  fifo_count;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  expQ[$];
   int          fallQ[$];
   int          cyc = 0;

   always #5 clk = ~clk;

   sample_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .tx         (tx),
      .busy       (busy),
      .full       (full),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic writeWord(input logic [31:0] w, input bit accept);
      wr_en   = 1'b1;
      wr_data = w;
      if (accept) for (int i = 3; i >= 0; i--) expQ.push_back(w[i*8 +: 8]);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while ((busy || fifo_count != 0 || expQ.size() != 0) && n < budget) begin
         tick(1);
         n++;
      end
      check({"drain ", name}, {31'd0, busy || fifo_count != 0 || expQ.size() != 0}, 32'd0);
      tick(3);
   endtask

   // Line monitor: samples mid-bit on falling clock edges.
   int         mState = 0;
   int         p = 0;
   logic [7:0] rxByte = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         mState = 0;
         p      = 0;
      end else if (mState == 0) begin
         if (tx === 1'b0) begin
            mState = 1;
            p      = 0;
            fallQ.push_back(cyc);
         end
      end else begin
         p++;
         if (p == CPB/2) begin
            check("start bit", {31'd0, tx}, 32'd0);
         end else if (p > CPB/2 && p < CPB/2 + 9*CPB && (p - CPB/2) % CPB == 0) begin
            rxByte = {tx, rxByte[7:1]};
         end else if (p == CPB/2 + 9*CPB) begin
            check("stop bit", {31'd0, tx}, 32'd1);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected byte: got %02h, expected none", rxByte);
            end else begin
               check("rx byte", {24'd0, rxByte}, {24'd0, expQ.pop_front()});
            end
            mState = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset tx", {31'd0, tx}, 32'd1);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset full", {31'd0, full}, 32'd0);
      check("reset overflow", {31'd0, overflow}, 32'd0);
      check("reset count", {29'd0, fifo_count}, 32'd0);
      rst = 1'b1;

      // Idle line
      for (int i = 0; i < 200; i++) begin
         tick(1);
         check("idle tx", {31'd0, tx}, 32'd1);
         check("idle busy", {31'd0, busy}, 32'd0);
      end

      // Single word: latency and duration
      writeWord(32'hA501FF3C, 1'b1);
      check("single count N", {29'd0, fifo_count}, 32'd1);
      check("single busy N", {31'd0, busy}, 32'd0);
      check("single tx N", {31'd0, tx}, 32'd1);
      tick(1);
      check("single count N+1", {29'd0, fifo_count}, 32'd0);
      check("single busy N+1", {31'd0, busy}, 32'd1);
      check("single tx N+1", {31'd0, tx}, 32'd1);
      tick(1);
      check("single tx N+2", {31'd0, tx}, 32'd0);
      tick(158);
      check("single busy N+160", {31'd0, busy}, 32'd1);
      tick(1);
      check("single busy N+161", {31'd0, busy}, 32'd0);
      check("single count N+161", {29'd0, fifo_count}, 32'd0);
      waitDrain("single", 50);

      // Burst of three words
      fallQ.delete();
      writeWord(32'h11111111, 1'b1);
      check("burst count 1", {29'd0, fifo_count}, 32'd1);
      writeWord(32'h22222222, 1'b1);
      check("burst count 2", {29'd0, fifo_count}, 32'd1);
      writeWord(32'h33333333, 1'b1);
      check("burst count peak", {29'd0, fifo_count}, 32'd2);
      tick(1);
      check("burst count hold", {29'd0, fifo_count}, 32'd2);
      waitDrain("burst", 600);
      check("burst start bits", fallQ.size(), 32'd12);
      for (int i = 1; i < fallQ.size(); i++)
         check("burst byte spacing", fallQ[i] - fallQ[i-1], (i % 4 == 0) ? 32'd41 : 32'd40);

      // Overflow: six writes, last one dropped
      for (int i = 1; i <= 5; i++) writeWord(32'hC0DE0000 + i, 1'b1);
      check("ovf full at 5", {31'd0, full}, 32'd1);
      check("ovf not yet", {31'd0, overflow}, 32'd0);
      writeWord(32'hDEADBEEF, 1'b0);
      check("ovf full", {31'd0, full}, 32'd1);
      check("ovf flag", {31'd0, overflow}, 32'd1);
      check("ovf count", {29'd0, fifo_count}, 32'd4);
      waitDrain("overflow", 1000);
      check("ovf sticky", {31'd0, overflow}, 32'd1);
      check("ovf full drained", {31'd0, full}, 32'd0);
      check("ovf count drained", {29'd0, fifo_count}, 32'd0);

      // Push in the same cycle IDLE pops
      writeWord(32'h0BADF00D, 1'b1);
      tick(2);
      writeWord(32'h600DCAFE, 1'b1);
      check("pp count before", {29'd0, fifo_count}, 32'd1);
      tick(158);
      check("pp idle gap", {31'd0, busy}, 32'd0);
      check("pp count idle", {29'd0, fifo_count}, 32'd1);
      writeWord(32'h5A5A1234, 1'b1);
      check("pp count after", {29'd0, fifo_count}, 32'd1);
      check("pp busy after", {31'd0, busy}, 32'd1);
      waitDrain("pushpop", 400);

      // Reset during data bits of the second byte
      writeWord(32'h12003456, 1'b1);
      tick(54);
      check("midreset tx low", {31'd0, tx}, 32'd0);
      check("midreset busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("midreset tx async", {31'd0, tx}, 32'd1);
      check("midreset busy clr", {31'd0, busy}, 32'd0);
      check("midreset count clr", {29'd0, fifo_count}, 32'd0);
      check("midreset ovf clr", {31'd0, overflow}, 32'd0);
      expQ.delete();
      tick(2);
      rst = 1'b1;
      tick(1);
      writeWord(32'h000000AA, 1'b1);
      waitDrain("after reset", 250);

      check("leftover bytes", expQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
